// File: rtl/xpt_sequencer.sv
// xpt_sequencer: M1 fetch T-state sequencer and execute-phase timer with wait states and HALT
module xpt_sequencer #(
  parameter int XPT_WIDTH = 5,
  parameter int FETCH_T = 4,
  parameter int WAIT_T = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 step,
  input  logic                 wait_req,
  input  logic                 reset_xpt,
  input  logic                 set_cm1,
  input  logic                 halt_req,
  input  logic                 int_req,
  output logic [XPT_WIDTH-1:0] XPT,
  output logic [XPT_WIDTH-1:0] notXPT,
  output logic                 cm1,
  output logic [1:0]           tstate,
  output logic                 fetch_done,
  output logic                 halted,
  output logic                 xpt_overflow
);
  typedef enum logic [1:0] {FETCH, EXEC, HALT} state_t;
  localparam logic [1:0] T_LAST = 2'(FETCH_T - 1);
  localparam logic [1:0] T_WAIT = 2'(WAIT_T);
  localparam logic [XPT_WIDTH-1:0] XPT_MAX = '1;
  state_t state_q;
  logic [XPT_WIDTH-1:0] xpt_q, nxpt_q;
  logic [1:0] tstate_q;
  logic cm1_q, fetch_done_q, halted_q, ovf_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= FETCH;
      xpt_q <= '0;
      nxpt_q <= '1;
      tstate_q <= 2'd0;
      cm1_q <= 1'b1;
      fetch_done_q <= 1'b0;
      halted_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      fetch_done_q <= 1'b0;
      if (step && state_q == FETCH) begin
        if (!(tstate_q == T_WAIT && wait_req)) begin
          if (tstate_q == T_LAST) begin
            state_q <= EXEC;
            fetch_done_q <= 1'b1;
            xpt_q <= '0;
            nxpt_q <= '1;
            cm1_q <= 1'b0;
            tstate_q <= 2'd0;
          end else begin
            tstate_q <= tstate_q + 2'd1;
          end
        end
      end else if (step && state_q == EXEC && !wait_req) begin
        if (reset_xpt) begin
          xpt_q <= '0;
          nxpt_q <= '1;
          if (set_cm1) begin
            state_q <= FETCH;
            cm1_q <= 1'b1;
            tstate_q <= 2'd0;
          end else if (halt_req) begin
            state_q <= HALT;
            halted_q <= 1'b1;
          end
        end else if (xpt_q == XPT_MAX) begin
          ovf_q <= 1'b1;
        end else begin
          xpt_q <= xpt_q + 1'b1;
          nxpt_q <= ~(xpt_q + 1'b1);
        end
      end else if (step && state_q == HALT && int_req) begin
        state_q <= FETCH;
        halted_q <= 1'b0;
        cm1_q <= 1'b1;
      end
    end
  end
  assign XPT = xpt_q;
  assign notXPT = nxpt_q;
  assign cm1 = cm1_q;
  assign tstate = tstate_q;
  assign fetch_done = fetch_done_q;
  assign halted = halted_q;
  assign xpt_overflow = ovf_q;
endmodule
